instruction_fetch: RTL and testbench

Fetch sequencer between the program counter and the decode/execute stage. Reads the current PC value, runs a request/acknowledge read to instruction memory, and holds the fetched word in an instruction register until decode accepts it. Drives the PC `pc_inc` and `pc_ld` controls, including branch redirects from execute, so the PC never advances on its own.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/instruction_fetch.sv | 125 ++++++++++++
 tb/tb_instruction_fetch.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared by the fetch sequencer, the PC and the control unit:
// fetch FSM encoding and default datapath widths.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_REQ  = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch sequencer: reads the word at the PC through a req/ack memory port,
// holds it in the IR until decode takes it, and steers the PC inc/load strobes.
//
// state  | meaning
// IDLE   | no request outstanding, IR empty
// REQ    | mem_req high, waiting for mem_ack
// HOLD   | IR holds a word for decode (ir_valid high)
module instruction_fetch #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_inc,
    output logic              pc_ld,
    output logic [ADDR_W-1:0] pc_target,
    input  logic              fetch_en,
    input  logic              br_req,
    input  logic [ADDR_W-1:0] br_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              ir_ready
);

    import cpu_pkg::*;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              squash;
    logic [ADDR_W-1:0] tgt_q;
    logic              load_addr;
    logic              load_ir;
    logic              squash_set;
    logic              squash_clr;
    logic              transfer;

    assign mem_req  = (state == S_REQ);
    assign ir_valid = (state == S_HOLD);
    assign transfer = ir_valid & ir_ready & ~br_req;

    always_comb begin
        state_nxt  = state;
        pc_inc     = 1'b0;
        pc_ld      = 1'b0;
        pc_target  = '0;
        load_addr  = 1'b0;
        load_ir    = 1'b0;
        squash_set = 1'b0;
        squash_clr = 1'b0;
        case (state)
            S_IDLE: begin
                if (br_req) begin
                    pc_ld     = 1'b1;
                    pc_target = br_target;
                end else if (fetch_en) begin
                    load_addr = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // A redirect seen during the request lets the read finish,
                // then throws the word away and loads the PC instead.
                if (mem_ack) begin
                    if (squash || br_req) begin
                        pc_ld      = 1'b1;
                        pc_target  = br_req ? br_target : tgt_q;
                        squash_clr = 1'b1;
                        state_nxt  = S_IDLE;
                    end else begin
                        load_ir   = 1'b1;
                        pc_inc    = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end else if (br_req) begin
                    squash_set = 1'b1;
                end
            end
            S_HOLD: begin
                if (br_req) begin
                    pc_ld     = 1'b1;
                    pc_target = br_target;
                    state_nxt = S_IDLE;
                end else if (transfer) begin
                    if (fetch_en) begin
                        load_addr = 1'b1;
                        state_nxt = S_REQ;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            squash   <= 1'b0;
            tgt_q    <= '0;
            mem_addr <= '0;
            ir_out   <= '0;
        end else begin
            state <= state_nxt;
            if (load_addr) begin
                mem_addr <= pc_addr;
            end
            if (load_ir) begin
                ir_out <= mem_rdata;
            end
            if (squash_set) begin
                squash <= 1'b1;
                tgt_q  <= br_target;
            end else if (squash_clr) begin
                squash <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the fetch unit plus its PC.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [15:0] pc_addr;
    logic        pc_inc;
    logic        pc_ld;
    logic [15:0] pc_target;
    logic        fetch_en;
    logic        br_req;
    logic [15:0] br_target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ready;

    int n_checks = 0;
    int n_errors = 0;

    // model: outstanding read, word waiting for decode, pending redirect, PC
    logic        m_busy, m_full, m_kill;
    logic [15:0] m_addr, m_ir, m_ktgt, m_pc;

    logic        obs_inc, obs_ld, obs_req, obs_valid;
    logic [15:0] obs_tgt, obs_addr, obs_ir;

    instruction_fetch #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_addr   (pc_addr),
        .pc_inc    (pc_inc),
        .pc_ld     (pc_ld),
        .pc_target (pc_target),
        .fetch_en  (fetch_en),
        .br_req    (br_req),
        .br_target (br_target),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir_out    (ir_out),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return a ^ 16'hA5D3;
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_busy = 1'b0; m_full = 1'b0; m_kill = 1'b0;
        m_addr = '0;   m_ir   = '0;   m_ktgt = '0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk_val({tag, "_req"},   mem_req,   0);
        chk_val({tag, "_addr"},  mem_addr,  0);
        chk_val({tag, "_ir"},    ir_out,    0);
        chk_val({tag, "_valid"}, ir_valid,  0);
        chk_val({tag, "_inc"},   pc_inc,    0);
        chk_val({tag, "_ld"},    pc_ld,     0);
        chk_val({tag, "_tgt"},   pc_target, 0);
    endtask

    // Asserted on a falling edge; a late ack is offered while reset is held.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        br_req = 1'b0;
        fetch_en = 1'b1;
        ir_ready = 1'b1;
        #1;
        chk_zero_outputs("rst_now");
        @(posedge clk);
        #1;
        chk_zero_outputs("rst_held");
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b0;
        fetch_en = 1'b0;
        model_clear();
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic cycle(input logic br, input logic [15:0] bt, input logic fen,
                         input logic ack, input logic rdy);
        logic        e_inc, e_ld;
        logic [15:0] e_tgt;
        logic        n_busy, n_full, n_kill;
        logic [15:0] n_addr, n_ir, n_ktgt;
        @(negedge clk);
        br_req = br;
        br_target = bt;
        fetch_en = fen;
        mem_ack = ack;
        ir_ready = rdy;
        pc_addr = m_pc;
        mem_rdata = ack ? word_at(m_addr) : 16'($urandom);
        #1;
        e_inc = 1'b0; e_ld = 1'b0; e_tgt = '0;
        if (m_busy) begin
            if (ack) begin
                if (m_kill || br) begin
                    e_ld = 1'b1;
                    e_tgt = br ? bt : m_ktgt;
                end else begin
                    e_inc = 1'b1;
                end
            end
        end else if (br) begin
            e_ld = 1'b1;
            e_tgt = bt;
        end
        chk_val("mem_req",   mem_req,   m_busy);
        chk_val("mem_addr",  mem_addr,  m_addr);
        chk_val("ir_valid",  ir_valid,  m_full);
        chk_val("ir_out",    ir_out,    m_ir);
        chk_val("pc_inc",    pc_inc,    e_inc);
        chk_val("pc_ld",     pc_ld,     e_ld);
        chk_val("pc_target", pc_target, e_tgt);
        chk_val("strobe_excl", pc_inc & pc_ld, 0);
        if (m_full && rdy && !br)
            chk_val("xfer_word", ir_out, word_at(m_addr));
        obs_inc = pc_inc; obs_ld = pc_ld; obs_tgt = pc_target;
        obs_req = mem_req; obs_addr = mem_addr; obs_valid = ir_valid; obs_ir = ir_out;

        n_busy = m_busy; n_full = m_full; n_kill = m_kill;
        n_addr = m_addr; n_ir = m_ir; n_ktgt = m_ktgt;
        if (m_busy) begin
            if (ack) begin
                n_busy = 1'b0;
                n_kill = 1'b0;
                if (!(m_kill || br)) begin
                    n_full = 1'b1;
                    n_ir = word_at(m_addr);
                end
            end else if (br) begin
                n_kill = 1'b1;
                n_ktgt = bt;
            end
        end else if (m_full) begin
            if (br) begin
                n_full = 1'b0;
            end else if (rdy) begin
                n_full = 1'b0;
                if (fen) begin
                    n_busy = 1'b1;
                    n_addr = m_pc;
                end
            end
        end else if (!br && fen) begin
            n_busy = 1'b1;
            n_addr = m_pc;
        end
        @(posedge clk);
        #1;
        m_busy = n_busy; m_full = n_full; m_kill = n_kill;
        m_addr = n_addr; m_ir = n_ir; m_ktgt = n_ktgt;
        if (e_inc) m_pc = m_pc + 16'd1;
        if (e_ld)  m_pc = e_tgt;
    endtask

    initial begin
        logic [15:0] held;
        reset = 1'b1;
        pc_addr = '0; fetch_en = 1'b0; br_req = 1'b0; br_target = '0;
        mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0;
        m_pc = '0;
        model_clear();
        #12;
        do_reset();

        // basic fetch with two ack wait cycles
        m_pc = 16'h0010;
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk_val("basic_addr", obs_addr, 16'h0010);
        chk_val("basic_req", obs_req, 1);
        cycle(0, 0, 1, 0, 0);
        chk_val("basic_wait_inc", obs_inc, 0);
        cycle(0, 0, 1, 1, 0);
        chk_val("basic_ack_inc", obs_inc, 1);
        repeat (3) begin
            cycle(0, 0, 1, 0, 0);
            chk_val("basic_hold_valid", obs_valid, 1);
            chk_val("basic_hold_ir", obs_ir, 16'hA5C3);
            chk_val("basic_hold_inc", obs_inc, 0);
        end
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        chk_val("basic_done_valid", obs_valid, 0);

        // streaming across the PC wrap
        m_pc = 16'hFFFE;
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 1, 1);
        chk_val("stream_a0", obs_addr, 16'hFFFE);
        cycle(0, 0, 1, 0, 1);
        chk_val("stream_h0", obs_valid, 1);
        cycle(0, 0, 1, 1, 1);
        chk_val("stream_a1", obs_addr, 16'hFFFF);
        chk_val("stream_r1", obs_req, 1);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 1, 1);
        chk_val("stream_a2", obs_addr, 16'h0000);
        chk_val("stream_r2", obs_req, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        // branch one cycle before ack
        m_pc = 16'h0100;
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 16'h0200, 1, 0, 0);
        chk_val("brreq_no_ld_early", obs_ld, 0);
        cycle(0, 16'h7777, 1, 1, 0);
        chk_val("brreq_ld", obs_ld, 1);
        chk_val("brreq_tgt", obs_tgt, 16'h0200);
        chk_val("brreq_inc", obs_inc, 0);
        cycle(0, 0, 1, 0, 0);
        chk_val("brreq_idle_valid", obs_valid, 0);
        cycle(0, 0, 1, 1, 0);
        chk_val("brreq_next_addr", obs_addr, 16'h0200);

        // branch in HOLD with ir_ready high
        cycle(1, 16'h0345, 1, 0, 1);
        chk_val("brhold_ld", obs_ld, 1);
        chk_val("brhold_tgt", obs_tgt, 16'h0345);
        chk_val("brhold_inc", obs_inc, 0);
        cycle(0, 0, 0, 0, 0);
        chk_val("brhold_valid", obs_valid, 0);
        chk_val("brhold_req", obs_req, 0);

        // backpressure then release with fetch_en low
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        held = word_at(16'h0345);
        repeat (5) begin
            cycle(0, 0, 1, 0, 0);
            chk_val("bp_ir_stable", obs_ir, held);
        end
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        chk_val("bp_idle_req", obs_req, 0);

        // reset while a request is outstanding
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk_val("rstreq_pre", obs_req, 1);
        do_reset();
        cycle(0, 0, 0, 1, 1);
        chk_val("rstreq_inc", obs_inc, 0);
        cycle(0, 0, 0, 0, 0);
        chk_val("rstreq_valid", obs_valid, 0);

        // random traffic
        m_pc = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 7) == 0), 16'($urandom),
                  ($urandom_range(0, 3) != 0), 1'($urandom),
                  1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
